// File: rtl/data_bus_controller.sv
// rtl/data_bus_controller.sv - data-port slave: byte-lane RAM, 8N1 UART transmitter, 64-bit cycle counter
// Reads are combinational; writes and all MMIO state update on the rising clock edge.
module data_bus_controller #(
  parameter int unsigned RAM_WORDS    = 1024,
  parameter string       INIT_FILE    = "",
  parameter int unsigned CLKS_PER_BIT = 434
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] memory_read_address,
  output logic [31:0] memory_read_data,
  input  logic [1:0]  memory_write_width,
  input  logic [31:0] memory_write_address,
  input  logic [31:0] memory_write_data,
  input  logic        memory_write_enable,
  output logic        uart_tx,
  output logic        misaligned_error
);
  localparam int AW = $clog2(RAM_WORDS);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [29:0] TXDATA_W = 30'h0400_0000;
  localparam logic [29:0] STATUS_W = 30'h0400_0001;
  localparam logic [29:0] CYC_LO_W = 30'h0400_0002;
  localparam logic [29:0] CYC_HI_W = 30'h0400_0003;

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  state_t          state_q;
  logic [7:0]      shift_q;
  logic [2:0]      bit_q;
  logic [CW-1:0]   baud_q;
  logic            tx_q, overrun_q, mis_q;
  logic [63:0]     cycle_q;
  logic [31:0]     mem_q [RAM_WORDS];

  logic [3:0]  wr_mask;
  logic [31:0] wr_lanes;
  logic        wr_bad;

  // Replicate the right-justified data across lanes; the mask picks which lanes land.
  always_comb begin
    wr_mask  = 4'b0000;
    wr_lanes = memory_write_data;
    wr_bad   = 1'b0;
    case (memory_write_width)
      2'b00: begin
        wr_mask  = 4'b0001 << memory_write_address[1:0];
        wr_lanes = {4{memory_write_data[7:0]}};
      end
      2'b01: begin
        wr_mask  = memory_write_address[1] ? 4'b1100 : 4'b0011;
        wr_lanes = {2{memory_write_data[15:0]}};
        wr_bad   = memory_write_address[0];
      end
      2'b10: begin
        wr_mask = 4'b1111;
        wr_bad  = |memory_write_address[1:0];
      end
      default: wr_bad = 1'b1;
    endcase
  end

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] lanes,
                                        input logic [3:0] mask);
    for (int b = 0; b < 4; b++) merge[8*b +: 8] = mask[b] ? lanes[8*b +: 8] : old[8*b +: 8];
  endfunction

  logic        wr_ok, ram_wr_hit, tx_wr, st_wr, lo_wr, hi_wr, baud_end, busy;
  logic [29:0] wr_word;
  logic        unused_rd_lanes;

  assign wr_ok      = memory_write_enable && !wr_bad;
  assign wr_word    = memory_write_address[31:2];
  assign ram_wr_hit = memory_write_address[31:AW+2] == '0;
  assign tx_wr      = wr_ok && wr_word == TXDATA_W && wr_mask[0];
  assign st_wr      = wr_ok && wr_word == STATUS_W;
  assign lo_wr      = wr_ok && wr_word == CYC_LO_W;
  assign hi_wr      = wr_ok && wr_word == CYC_HI_W;
  assign baud_end   = baud_q == CW'(CLKS_PER_BIT - 1);
  assign busy       = state_q != S_IDLE;
  assign unused_rd_lanes = ^memory_read_address[1:0];

  always_ff @(posedge clk) begin
    if (wr_ok && ram_wr_hit) begin
      for (int b = 0; b < 4; b++)
        if (wr_mask[b]) mem_q[memory_write_address[AW+1:2]][8*b +: 8] <= wr_lanes[8*b +: 8];
    end
  end

  // Reads see pre-edge state, so a same-cycle write to the same location returns the old value.
  always_comb begin
    memory_read_data = '0;
    if (memory_read_address[31:AW+2] == '0) begin
      memory_read_data = mem_q[memory_read_address[AW+1:2]];
    end else begin
      case (memory_read_address[31:2])
        STATUS_W: memory_read_data = {30'b0, overrun_q, busy};
        CYC_LO_W: memory_read_data = cycle_q[31:0];
        CYC_HI_W: memory_read_data = cycle_q[63:32];
        default:  memory_read_data = '0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      shift_q   <= '0;
      bit_q     <= '0;
      baud_q    <= '0;
      tx_q      <= 1'b1;
      overrun_q <= 1'b0;
      mis_q     <= 1'b0;
      cycle_q   <= '0;
    end else begin
      mis_q <= memory_write_enable && wr_bad;

      if (tx_wr && busy)  overrun_q <= 1'b1;
      else if (st_wr)     overrun_q <= 1'b0;

      if (lo_wr)          cycle_q[31:0]  <= merge(cycle_q[31:0], wr_lanes, wr_mask);
      else if (hi_wr)     cycle_q[63:32] <= merge(cycle_q[63:32], wr_lanes, wr_mask);
      else                cycle_q        <= cycle_q + 64'd1;

      baud_q <= (!busy || baud_end) ? '0 : baud_q + CW'(1);

      case (state_q)
        S_IDLE: if (tx_wr) begin
          state_q <= S_START;
          shift_q <= wr_lanes[7:0];
          tx_q    <= 1'b0;
        end
        S_START: if (baud_end) begin
          state_q <= S_DATA;
          tx_q    <= shift_q[0];
          bit_q   <= '0;
        end
        S_DATA: if (baud_end) begin
          shift_q <= shift_q >> 1;
          bit_q   <= bit_q + 3'd1;
          if (bit_q == 3'd7) begin
            state_q <= S_STOP;
            tx_q    <= 1'b1;
          end else begin
            tx_q <= shift_q[1];
          end
        end
        S_STOP: if (baud_end) state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign uart_tx          = tx_q;
  assign misaligned_error = mis_q;
endmodule

// File: tb/tb_data_bus_controller.sv
// tb/tb_data_bus_controller.sv - directed and randomized bench for data_bus_controller
// Reference model works on a byte-addressed view of the map and a frame start time for the UART.
module tb_data_bus_controller;
  localparam int RW    = 64;
  localparam int C     = 4;
  localparam int FRAME = 10 * C;
  localparam logic [31:0] TX = 32'h1000_0000, ST = 32'h1000_0004;
  localparam logic [31:0] LO = 32'h1000_0008, HI = 32'h1000_000C;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [31:0] memory_read_address = '0;
  logic [31:0] memory_read_data;
  logic [1:0]  memory_write_width = '0;
  logic [31:0] memory_write_address = '0;
  logic [31:0] memory_write_data = '0;
  logic        memory_write_enable = 1'b0;
  logic        uart_tx;
  logic        misaligned_error;

  always #5 clk = ~clk;

  data_bus_controller #(.RAM_WORDS(RW), .CLKS_PER_BIT(C)) dut (
    .clk(clk), .rst_n(rst_n),
    .memory_read_address(memory_read_address), .memory_read_data(memory_read_data),
    .memory_write_width(memory_write_width), .memory_write_address(memory_write_address),
    .memory_write_data(memory_write_data), .memory_write_enable(memory_write_enable),
    .uart_tx(uart_tx), .misaligned_error(misaligned_error)
  );

  int checks = 0, errors = 0;
  logic [7:0]  ram_m [RW*4];
  logic [63:0] cyc_m = '0;
  logic        ovr_m = 1'b0, mis_m = 1'b0, frame_m = 1'b0;
  logic [7:0]  txb_m = '0;
  int          ecount = 0, tx_e = 0;
  logic [9:0]  pat_a5 = 10'b1101001010;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic m_busy(input int at);
    return frame_m && (at - tx_e) < FRAME;
  endfunction

  function automatic logic m_tx(input int at);
    int b;
    if (!m_busy(at)) return 1'b1;
    b = (at - tx_e) / C;
    if (b == 0) return 1'b0;
    if (b == 9) return 1'b1;
    return txb_m[b-1];
  endfunction

  function automatic logic [31:0] m_read(input logic [31:0] a);
    logic [31:0] w;
    w = {a[31:2], 2'b00};
    if (w < RW*4) return {ram_m[w+3], ram_m[w+2], ram_m[w+1], ram_m[w]};
    if (w == ST)  return {30'b0, ovr_m, m_busy(ecount)};
    if (w == LO)  return cyc_m[31:0];
    if (w == HI)  return cyc_m[63:32];
    return '0;
  endfunction

  function automatic logic m_bad(input logic [1:0] wd, input logic [31:0] a);
    return wd == 2'b11 || (int'(a[1:0]) % (1 << wd)) != 0;
  endfunction

  // Applies one accepted write byte by byte; reports whether the counter was written.
  task automatic m_write(input logic [1:0] wd, input logic [31:0] a, input logic [31:0] d,
                         output logic cnt_wr);
    logic [31:0] ba;
    logic [7:0]  bv;
    int          off;
    cnt_wr = 1'b0;
    for (int i = 0; i < (1 << wd); i++) begin
      ba = a + i;
      bv = d[8*i +: 8];
      if (ba < RW*4) ram_m[ba] = bv;
      else if (ba == TX) begin
        if (m_busy(ecount - 1)) ovr_m = 1'b1;
        else begin frame_m = 1'b1; tx_e = ecount; txb_m = bv; end
      end
      else if (ba[31:2] == ST[31:2]) ovr_m = 1'b0;
      else if (ba >= LO && ba < HI + 4) begin
        off = int'(ba - LO);
        cyc_m[8*off +: 8] = bv;
        cnt_wr = 1'b1;
      end
    end
  endtask

  task automatic tick();
    logic cw;
    @(posedge clk);
    ecount++;
    if (!rst_n) begin
      cyc_m = '0;
      mis_m = 1'b0;
    end else begin
      cw = 1'b0;
      mis_m = memory_write_enable && m_bad(memory_write_width, memory_write_address);
      if (memory_write_enable && !mis_m)
        m_write(memory_write_width, memory_write_address, memory_write_data, cw);
      if (!cw) cyc_m = cyc_m + 64'd1;
    end
    @(negedge clk);
    chk("uart_tx", uart_tx, m_tx(ecount));
    chk("misaligned_error", misaligned_error, mis_m);
  endtask

  task automatic wr(input logic [1:0] wd, input logic [31:0] a, input logic [31:0] d);
    memory_write_width   = wd;
    memory_write_address = a;
    memory_write_data    = d;
    memory_write_enable  = 1'b1;
    memory_read_address  = a;
    #1;
    chk("read_old_value", memory_read_data, m_read(a));
    tick();
    memory_write_enable = 1'b0;
  endtask

  task automatic rd(input string tag, input logic [31:0] a);
    memory_read_address = a;
    #1;
    chk(tag, memory_read_data, m_read(a));
  endtask

  function automatic logic [31:0] rand_addr();
    case ($urandom_range(0, 9))
      0, 1, 2, 3, 4: return 32'($urandom_range(0, RW*4 - 1));
      5:             return TX + 32'($urandom_range(0, 3));
      6:             return ST + 32'($urandom_range(0, 3));
      7:             return LO + 32'($urandom_range(0, 3));
      8:             return HI + 32'($urandom_range(0, 3));
      default:       return (($urandom_range(0, 1) == 0) ? 32'(RW*4) : 32'h2000_0000)
                            + 32'($urandom_range(0, 15));
    endcase
  endfunction

  initial begin
    #2 rst_n = 1'b0;
    memory_read_address = ST;
    #1;
    chk("reset_uart_tx", uart_tx, 1'b1);
    chk("reset_misaligned", misaligned_error, 1'b0);
    chk("reset_status", memory_read_data, 32'h0);
    tick();
    memory_read_address = LO;
    #1 chk("reset_counter", memory_read_data, 32'h0);
    rst_n = 1'b1;

    for (int w = 0; w < RW; w++) wr(2'b10, 32'(4*w), $urandom);

    wr(2'b10, 32'h10, 32'hDEADBEEF);
    wr(2'b00, 32'h11, 32'h55);
    rd("ram_sb", 32'h10);
    chk("ram_sb_lit", memory_read_data, 32'hDEAD55EF);
    wr(2'b01, 32'h12, 32'h1234);
    rd("ram_sh", 32'h13);
    chk("ram_sh_lit", memory_read_data, 32'h123455EF);

    wr(2'b01, 32'h3, 32'hAAAA);
    chk("mis_half_lit", misaligned_error, 1'b1);
    tick();
    chk("mis_pulse_end", misaligned_error, 1'b0);
    wr(2'b10, 32'h6, 32'h11111111);
    wr(2'b11, 32'h8, 32'h22222222);
    chk("mis_reserved_lit", misaligned_error, 1'b1);
    rd("ram_keep0", 32'h0);
    rd("ram_keep4", 32'h4);
    rd("ram_keep8", 32'h8);

    wr(2'b00, TX, 32'hA5);
    for (int k = 0; k < FRAME; k++) begin
      memory_read_address = ST;
      #1;
      chk("status_frame", memory_read_data, (k > 12 && k <= 20) ? 32'h3 : 32'h1);
      chk("a5_bit", uart_tx, pat_a5[k / C]);
      if (k == 12)      wr(2'b00, TX, 32'h3C);
      else if (k == 20) wr(2'b10, ST, $urandom);
      else              tick();
    end
    memory_read_address = ST;
    #1 chk("status_idle", memory_read_data, 32'h0);

    wr(2'b10, LO, 32'hFFFF_FFFF);
    rd("cyc_lo_written", LO);
    chk("cyc_lo_lit", memory_read_data, 32'hFFFF_FFFF);
    wr(2'b10, HI, 32'h0);
    rd("cyc_hi_written", HI);
    chk("cyc_hi_lit", memory_read_data, 32'h0);
    tick();
    rd("cyc_carry_hi", HI);
    chk("cyc_carry_hi_lit", memory_read_data, 32'h1);
    rd("cyc_carry_lo", LO);
    chk("cyc_carry_lo_lit", memory_read_data, 32'h0);

    wr(2'b00, TX, 32'h81);
    repeat (7) tick();
    memory_read_address = ST;
    #2 rst_n = 1'b0;
    frame_m = 1'b0; ovr_m = 1'b0; cyc_m = '0; mis_m = 1'b0;
    #1;
    chk("abort_uart_tx", uart_tx, 1'b1);
    chk("abort_status", memory_read_data, 32'h0);
    rd("ram_retained", 32'h10);
    chk("ram_retained_lit", memory_read_data, 32'h123455EF);
    repeat (2) tick();
    rst_n = 1'b1;
    memory_read_address = LO;
    #1 chk("counter_after_reset", memory_read_data, 32'h0);

    for (int n = 0; n < 1500; n++) begin
      rd("rand_read", rand_addr());
      if ($urandom_range(0, 9) < 7) wr(2'($urandom_range(0, 3)), rand_addr(), $urandom);
      else                          tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
